count_seq_ctrl: RTL and testbench

// Run controller for the lab 4-bit up counter datapath: sequences start/pause/clear,

---
 rtl/count_seq_ctrl_pkg.sv | 25 ++
 rtl/count_seq_ctrl_prescaler.sv | 47 ++++
 rtl/count_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_count_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_ctrl_pkg
// Shared definitions for the counter run controller: the run-state encoding
// seen on the 'state' output, default widths and a small state helper.
// ---------------------------------------------------------------------------
package count_seq_ctrl_pkg;

    // Default counter width (Q, term) and prescaler width (div)
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DIV_W = 8;

    // Encoding is visible on the board LEDs, so the values are fixed
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // IDLE and DONE are the only states where a start latches fresh config
    function automatic logic is_restartable(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/count_seq_ctrl_prescaler.sv
// ---------------------------------------------------------------------------
// cnt_prescaler
// Divides the system clock into count ticks: while enabled the phase counter
// runs 0..div and 'tick' is high in the cycle where it sits at div, after
// which it returns to 0. Disabled, the phase is frozen so a paused run
// resumes in the same phase.
// Ports:
//   clk    in  1      system clock, rising edge
//   reset  in  1      asynchronous, active-high reset
//   en     in  1      advance the phase this cycle
//   clr    in  1      force the phase back to 0 (wins over en)
//   div    in  DIV_W  tick period minus one
//   tick   out 1      high while enabled and the phase equals div
// ---------------------------------------------------------------------------
module cnt_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] phase;

    // Tick is combinational on the phase register and only consumed
    // inside the controller, so no input reaches a top-level output
    assign tick = en && (phase == div);

    // Phase counter: clear has priority, wraps to 0 on the tick cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            if (phase == div) begin
                phase <= '0;
            end else begin
                phase <= phase + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// count_seq_ctrl
// Run controller for the lab up counter: sequences start/pause/clear,
// divides the clock into count ticks and detects a programmable terminal
// count in one-shot or auto-reload mode.
// Ports:
//   clk        in  1      system clock, rising edge
//   reset      in  1      asynchronous, active-high reset
//   start      in  1      begin (IDLE/DONE) or resume (HOLD) counting
//   stop       in  1      pause counting, RUN -> HOLD
//   clear      in  1      abort to IDLE with Q=0
//   mode_auto  in  1      1 = wrap to 0 at terminal, 0 = stop at terminal
//   term       in  WIDTH  terminal count, latched on start from IDLE/DONE
//   div        in  DIV_W  tick every div+1 clocks, latched with term
//   Q          out WIDTH  counter value
//   busy       out 1      high while in RUN
//   done       out 1      one-cycle pulse after a terminal tick
//   state      out 2      IDLE=00 RUN=01 HOLD=10 DONE=11
// ---------------------------------------------------------------------------
import count_seq_ctrl_pkg::*;

module count_seq_ctrl #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode_auto,
    input  logic [WIDTH-1:0] term,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t           st;
    logic [WIDTH-1:0] count;
    logic             done_r;
    logic [WIDTH-1:0] term_l;
    logic [DIV_W-1:0] div_l;
    logic             auto_l;
    logic             tick;
    logic             launch;
    logic             pre_clr;

    // A fresh run starts only from IDLE/DONE, and stop outranks start
    assign launch  = !clear && !stop && start && is_restartable(st);
    assign pre_clr = clear || launch;

    // The prescaler keeps running in the stop cycle so the dropped tick
    // still consumes its period; a resume then waits a full div_l+1
    cnt_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (st == ST_RUN),
        .clr   (pre_clr),
        .div   (div_l),
        .tick  (tick)
    );

    // Main sequencer: command priority clear > stop > start > tick.
    // Q, the done pulse and the shadow configuration all live here so
    // every output comes straight from a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= ST_IDLE;
            count  <= '0;
            done_r <= 1'b0;
            term_l <= '0;
            div_l  <= '0;
            auto_l <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (clear) begin
                st    <= ST_IDLE;
                count <= '0;
            end else begin
                case (st)
                    ST_IDLE, ST_DONE: begin
                        if (launch) begin
                            st     <= ST_RUN;
                            count  <= '0;
                            term_l <= term;
                            div_l  <= div;
                            auto_l <= mode_auto;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            st <= ST_HOLD;
                        end else if (tick) begin
                            if (count == term_l) begin
                                done_r <= 1'b1;
                                if (auto_l) begin
                                    count <= '0;
                                end else begin
                                    st <= ST_DONE;
                                end
                            end else begin
                                count <= count + WIDTH'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!stop && start) begin
                            st <= ST_RUN;
                        end
                    end
                    default: begin
                        st <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Q     = count;
    assign done  = done_r;
    assign busy  = (st == ST_RUN);
    assign state = st;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_seq_ctrl
// Drives directed scenarios and random command streams into count_seq_ctrl
// and compares Q/state/busy/done every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_count_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clear;
    logic       mode_auto;
    logic [3:0] term;
    logic [7:0] div;
    logic [3:0] Q;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int errorCount;
    int checkCount;

    // Reference model: run mode, count, RUN cycles since period start, config
    int mMode;
    int mQ;
    int mRunCycles;
    int mTerm;
    int mDiv;
    int mAuto;
    int mDone;

    count_seq_ctrl #(
        .WIDTH (4),
        .DIV_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .mode_auto (mode_auto),
        .term      (term),
        .div       (div),
        .Q         (Q),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when it differs
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model reset: everything back to zero, idle
    task automatic modelReset();
        mMode = 0; mQ = 0; mRunCycles = 0;
        mTerm = 0; mDiv = 0; mAuto = 0; mDone = 0;
    endtask

    // Whether the next RUN edge lands on a tick (every mDiv+1 RUN cycles)
    function automatic bit modelTickNext();
        return ((mRunCycles + 1) % (mDiv + 1)) == 0;
    endfunction

    // Model of one rising edge given the inputs held across it
    task automatic modelStep(input bit s, input bit p, input bit c, input bit a,
                             input int t, input int d);
        bit tickNow;
        mDone = 0;
        if (c) begin
            mMode = 0; mQ = 0; mRunCycles = 0;
        end else if (mMode == 0 || mMode == 3) begin
            if (s && !p) begin
                mMode = 1; mQ = 0; mRunCycles = 0;
                mTerm = t; mDiv = d; mAuto = a;
            end
        end else if (mMode == 1) begin
            tickNow = modelTickNext();
            mRunCycles++;
            if (p) begin
                mMode = 2;
            end else if (tickNow) begin
                if (mQ == mTerm) begin
                    mDone = 1;
                    if (mAuto != 0) mQ = 0;
                    else mMode = 3;
                end else begin
                    mQ++;
                end
            end
        end else begin
            if (s && !p) mMode = 1;
        end
    endtask

    // Compare all outputs to the model
    task automatic compareAll(input string tag);
        checkOutput({tag, ".Q"}, int'(Q), mQ);
        checkOutput({tag, ".state"}, int'(state), mMode);
        checkOutput({tag, ".busy"}, int'(busy), (mMode == 1) ? 1 : 0);
        checkOutput({tag, ".done"}, int'(done), mDone);
    endtask

    // One cycle: check last edge's result at negedge, then drive and predict
    task automatic applyStimulus(input string tag, input bit s, input bit p, input bit c,
                                 input bit a, input int t, input int d);
        @(negedge clk);
        compareAll(tag);
        start = s; stop = p; clear = c; mode_auto = a;
        term = 4'(t); div = 8'(d);
        modelStep(s, p, c, a, t, d);
    endtask

    initial begin
        bit reached;
        errorCount = 0;
        checkCount = 0;
        start = 0; stop = 0; clear = 0; mode_auto = 0; term = 0; div = 0;
        modelReset();
        reset = 1'b1;
        #3;
        compareAll("reset");
        #10;
        @(negedge clk);
        reset = 1'b0;

        // One-shot, term=3, div=0: Q 0,1,2,3 then DONE holding 3
        applyStimulus("oneshot", 1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 7; i++) applyStimulus("oneshot", 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        checkOutput("oneshotHoldQ", int'(Q), 3);
        checkOutput("oneshotState", int'(state), 3);

        // Auto-reload, term=2, div=2: count every 3 clocks, wrap with done
        applyStimulus("auto", 1, 0, 0, 1, 2, 2);
        for (int i = 0; i < 18; i++) applyStimulus("auto", 0, 0, 0, 1, 2, 2);

        // Stop exactly on a tick at Q=4, then resume
        applyStimulus("stopTick", 0, 0, 1, 0, 0, 0);
        applyStimulus("stopTick", 1, 0, 0, 0, 9, 2);
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (mQ == 4 && mMode == 1 && modelTickNext()) reached = 1;
            else applyStimulus("stopTick", 0, 0, 0, 0, 9, 2);
        end
        checkOutput("stopTickReached", int'(reached), 1);
        applyStimulus("stopTick", 0, 1, 0, 0, 9, 2);
        for (int i = 0; i < 3; i++) applyStimulus("stopHold", 0, 0, 0, 0, 5, 0);
        applyStimulus("resume", 1, 0, 0, 0, 5, 0);
        for (int i = 0; i < 5; i++) applyStimulus("resume", 0, 0, 0, 0, 5, 0);

        // Clear with stop and start on a terminal tick: IDLE, no done
        applyStimulus("clrTerm", 0, 0, 1, 0, 0, 0);
        applyStimulus("clrTerm", 1, 0, 0, 1, 2, 0);
        reached = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (mQ == 2 && mMode == 1) reached = 1;
            else applyStimulus("clrTerm", 0, 0, 0, 1, 2, 0);
        end
        checkOutput("clrTermReached", int'(reached), 1);
        applyStimulus("clrTerm", 1, 1, 1, 1, 2, 0);
        applyStimulus("clrTerm", 0, 0, 0, 1, 2, 0);
        applyStimulus("clrTerm", 0, 0, 0, 1, 2, 0);

        // term=0, auto, div=1: Q stays 0, done every second clock
        applyStimulus("term0", 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus("term0", 0, 0, 0, 1, 7, 3);

        // Async reset in RUN at Q=5, observed before any clock edge
        applyStimulus("asyncRst", 0, 0, 1, 0, 0, 0);
        applyStimulus("asyncRst", 1, 0, 0, 0, 9, 0);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (mQ == 5) reached = 1;
            else applyStimulus("asyncRst", 0, 0, 0, 0, 9, 0);
        end
        checkOutput("asyncRstReached", int'(reached), 1);
        @(negedge clk);
        compareAll("asyncRstPre");
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncRst.Q", int'(Q), 0);
        checkOutput("asyncRst.state", int'(state), 0);
        checkOutput("asyncRst.busy", int'(busy), 0);
        checkOutput("asyncRst.done", int'(done), 0);
        #1 reset = 1'b0;

        // Random command streams with small term/div so terminals happen
        for (int i = 0; i < 3000; i++) begin
            bit rs, rp, rc, ra;
            int rt, rd;
            rs = ($urandom_range(3) == 0);
            rp = ($urandom_range(9) == 0);
            rc = ($urandom_range(24) == 0);
            ra = $urandom_range(1) != 0;
            rt = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(3));
            rd = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(3));
            applyStimulus("random", rs, rp, rc, ra, rt, rd);
        end
        applyStimulus("final", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
